// File: rtl/ecc_ctrl_pkg.sv
// Shared types and defaults for the ECC host/core sequencer.
package ecc_ctrl_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 4096;

  localparam logic MODE_PA  = 1'b0;
  localparam logic MODE_PAB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/ecc_shift_reg.sv
// Parameterized shift register: parallel load, MSB-first serial in/out.
module ecc_shift_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = q[WIDTH-1];

endmodule

// File: rtl/ecc_ctrl.sv
// Sequencer between the bit-serial host interface and the parallel ECC core:
// deserializes operands, starts the core under a watchdog, serializes results.
module ecc_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_p_a_valid,
  input  logic             i_pb_valid,
  input  logic             i_mode,
  input  logic             i_p,
  input  logic             i_x,
  input  logic             i_y,
  input  logic             i_a,
  input  logic             i_Pb,
  output logic             core_start,
  output logic             core_mode,
  output logic [WIDTH-1:0] core_p,
  output logic [WIDTH-1:0] core_gx,
  output logic [WIDTH-1:0] core_gy,
  output logic [WIDTH-1:0] core_k,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_rx,
  input  logic [WIDTH-1:0] core_ry,
  output logic             o_Pa_valid,
  output logic             o_x,
  output logic             o_y,
  output logic             o_Pab_valid,
  output logic             o_Pab,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned BC_W = $clog2(2 * WIDTH);
  localparam int unsigned OC_W = $clog2(WIDTH);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_t state, state_nx;

  logic            pa_prev, pb_prev;
  logic            key_loaded;
  logic            mode_q;
  logic [BC_W-1:0] bit_cnt;
  logic [OC_W-1:0] out_cnt;
  logic [WD_W-1:0] wd_cnt;

  logic start_edge, go_load0, go_load1, key_err, wd_expire;
  logic cap0, cap1x, cap1y, res_load, res_shift;
  logic rx_msb, ry_msb;

  logic [3:0]       ser_unused;
  logic [WIDTH-1:0] rx_par_unused, ry_par_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    start_edge  = 1'b0;
    go_load0    = 1'b0;
    go_load1    = 1'b0;
    key_err     = 1'b0;
    wd_expire   = 1'b0;
    cap0        = 1'b0;
    cap1x       = 1'b0;
    cap1y       = 1'b0;
    res_load    = 1'b0;
    res_shift   = 1'b0;
    o_Pa_valid  = 1'b0;
    o_Pab_valid = 1'b0;
    o_x         = 1'b0;
    o_y         = 1'b0;
    o_Pab       = 1'b0;
    o_busy      = (state != ST_IDLE);
    state_nx    = state;

    // Only the valid line chosen by i_mode can open a frame.
    if (state == ST_IDLE) begin
      if (i_mode == MODE_PAB) begin
        start_edge = i_pb_valid && !pb_prev;
      end else begin
        start_edge = i_p_a_valid && !pa_prev;
      end
    end
    go_load0  = start_edge && (i_mode == MODE_PA);
    go_load1  = start_edge && (i_mode == MODE_PAB) && key_loaded;
    key_err   = start_edge && (i_mode == MODE_PAB) && !key_loaded;
    wd_expire = (state == ST_WAIT) && !core_done && (wd_cnt == WD_W'(TIMEOUT - 1));

    cap0  = go_load0 || ((state == ST_LOAD0) && i_p_a_valid);
    cap1x = go_load1 || ((state == ST_LOAD1) && i_pb_valid && (bit_cnt < BC_W'(WIDTH)));
    cap1y = (state == ST_LOAD1) && i_pb_valid && (bit_cnt >= BC_W'(WIDTH));

    res_load  = (state == ST_WAIT) && core_done;
    res_shift = (state == ST_OUT);

    if (state == ST_OUT) begin
      o_Pa_valid  = (core_mode == MODE_PA);
      o_Pab_valid = (core_mode == MODE_PAB);
      o_x         = o_Pa_valid && rx_msb;
      o_y         = o_Pa_valid && ry_msb;
      o_Pab       = o_Pab_valid && rx_msb;
    end

    case (state)
      ST_IDLE: begin
        if (go_load0) begin
          state_nx = ST_LOAD0;
        end else if (go_load1) begin
          state_nx = ST_LOAD1;
        end
      end
      ST_LOAD0: begin
        if (!i_p_a_valid) begin
          state_nx = ST_IDLE;
        end else if (bit_cnt == BC_W'(WIDTH - 1)) begin
          state_nx = ST_START;
        end
      end
      ST_LOAD1: begin
        if (!i_pb_valid) begin
          state_nx = ST_IDLE;
        end else if (bit_cnt == BC_W'(2 * WIDTH - 1)) begin
          state_nx = ST_START;
        end
      end
      ST_START: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          state_nx = ST_OUT;
        end else if (wd_expire) begin
          state_nx = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_cnt == OC_W'(WIDTH - 1)) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_prev    <= 1'b0;
      pb_prev    <= 1'b0;
      key_loaded <= 1'b0;
      mode_q     <= MODE_PA;
      core_start <= 1'b0;
      core_mode  <= MODE_PA;
      o_err      <= 1'b0;
      bit_cnt    <= '0;
      out_cnt    <= '0;
      wd_cnt     <= '0;
    end else begin
      pa_prev    <= i_p_a_valid;
      pb_prev    <= i_pb_valid;
      o_err      <= key_err || wd_expire;
      core_start <= (state_nx == ST_START);

      if (start_edge) begin
        mode_q <= i_mode;
      end
      if (state_nx == ST_START) begin
        core_mode <= mode_q;
      end

      // A partial mode-0 load has already clobbered core_k.
      if (state == ST_LOAD0) begin
        if (state_nx == ST_START) begin
          key_loaded <= 1'b1;
        end else if (state_nx == ST_IDLE) begin
          key_loaded <= 1'b0;
        end
      end

      if (go_load0 || go_load1) begin
        bit_cnt <= BC_W'(1);
      end else if (((state == ST_LOAD0) || (state == ST_LOAD1)) && (state_nx == state)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end

      // The watchdog window includes the START cycle.
      if ((state == ST_START) || (state == ST_WAIT)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end

      if ((state == ST_OUT) && (state_nx == ST_OUT)) begin
        out_cnt <= out_cnt + 1'b1;
      end else begin
        out_cnt <= '0;
      end
    end
  end

  ecc_shift_reg #(.WIDTH(WIDTH)) u_p (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift_en(cap0), .serial_in(i_p),
    .q(core_p), .serial_out(ser_unused[0])
  );

  ecc_shift_reg #(.WIDTH(WIDTH)) u_gx (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift_en(cap0 || cap1x), .serial_in(cap1x ? i_Pb : i_x),
    .q(core_gx), .serial_out(ser_unused[1])
  );

  ecc_shift_reg #(.WIDTH(WIDTH)) u_gy (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift_en(cap0 || cap1y), .serial_in(cap1y ? i_Pb : i_y),
    .q(core_gy), .serial_out(ser_unused[2])
  );

  ecc_shift_reg #(.WIDTH(WIDTH)) u_k (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift_en(cap0), .serial_in(i_a),
    .q(core_k), .serial_out(ser_unused[3])
  );

  ecc_shift_reg #(.WIDTH(WIDTH)) u_rx (
    .clk(clk), .rst(rst), .load(res_load), .load_data(core_rx),
    .shift_en(res_shift), .serial_in(1'b0),
    .q(rx_par_unused), .serial_out(rx_msb)
  );

  ecc_shift_reg #(.WIDTH(WIDTH)) u_ry (
    .clk(clk), .rst(rst), .load(res_load), .load_data(core_ry),
    .shift_en(res_shift), .serial_in(1'b0),
    .q(ry_par_unused), .serial_out(ry_msb)
  );

endmodule
